// File: rtl/transito_pkg.sv
// Shared types and elaboration helpers for the intersection controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package transito_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        IDLE   = 3'd1,
        GREEN  = 3'd2,
        YELLOW = 3'd3,
        WALK   = 3'd4
    } state_t;

    // Largest of four durations; sizes the shared phase timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin finder: first set req bit after 'last', wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; idx is meaningful only when any=1.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] j;

    // Walk offsets from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        idx = last;
        any = 1'b0;
        j   = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(last) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/transito_multi.sv
// N-approach intersection controller: demand latches, round-robin actuated green, clearance, walk, red-light cameras.
// Latency: demand latched 1 cycle after det/ped_req; lamps follow state (change the cycle after a transition); cam 1 cycle after stop edge.
// Backpressure: none; detector inputs are sampled levels, outputs drive lamps directly.
module transito_multi
    import transito_pkg::*;
#(
    parameter int N_WAYS    = 4,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 24,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_WAYS-1:0] det,
    input  logic [N_WAYS-1:0] stop,
    input  logic              ped_req,
    output logic [N_WAYS-1:0] green,
    output logic [N_WAYS-1:0] yellow,
    output logic [N_WAYS-1:0] red,
    output logic              ped_walk,
    output logic [N_WAYS-1:0] cam
);

    localparam int TMAX = max4(GREEN_MAX, WALK_T, YELLOW_T, ALLRED_T);
    localparam int TW   = clog2_min1(TMAX);
    localparam int CW   = clog2_min1(N_WAYS);

    localparam logic [TW-1:0] ALLRED_END = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] WALK_END   = TW'(WALK_T - 1);
    localparam logic [TW-1:0] GMIN_END   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_END   = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] TMR_TOP    = TW'(TMAX - 1);
    localparam logic [CW-1:0] CUR_RST    = CW'(N_WAYS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cur;
    logic [TW-1:0]     tmr;
    logic [TW-1:0]     tmr_sat;
    logic [N_WAYS-1:0] dem;
    logic [N_WAYS-1:0] stop_q;
    logic              ped_pend;
    logic [CW-1:0]     pick_idx;
    logic              pick_any;
    logic              competing;
    logic              enter_green;
    logic              enter_walk;

    rr_pick #(
        .N (N_WAYS),
        .W (CW)
    ) u_pick (
        .req  (dem),
        .last (cur),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Anything other than the served approach that would justify ending green.
    assign competing   = (|(dem & ~(N_WAYS'(1) << cur))) | ped_pend;
    assign enter_green = (state != GREEN) && (state_nxt == GREEN);
    assign enter_walk  = (state != WALK)  && (state_nxt == WALK);
    assign tmr_sat     = (state == GREEN) ? GMAX_END : TMR_TOP;

    // State register; reset lands in all-red clearance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ALLRED;
        else        state <= state_nxt;
    end

    // Next-state: pedestrian beats vehicles at every selection point; green only ends under competition.
    always_comb begin
        state_nxt = state;
        case (state)
            ALLRED: if (tmr == ALLRED_END) begin
                if (ped_pend)      state_nxt = WALK;
                else if (pick_any) state_nxt = GREEN;
                else               state_nxt = IDLE;
            end
            IDLE: begin
                if (ped_pend)      state_nxt = WALK;
                else if (pick_any) state_nxt = GREEN;
            end
            GREEN: if (competing && ((tmr == GMAX_END) || ((tmr >= GMIN_END) && !det[cur])))
                state_nxt = YELLOW;
            YELLOW: if (tmr == YELLOW_END) state_nxt = ALLRED;
            WALK:   if (tmr == WALK_END)   state_nxt = ALLRED;
            default: state_nxt = ALLRED;
        endcase
    end

    // Moore lamp decode; red is the complement so each approach shows exactly one colour.
    always_comb begin
        green    = '0;
        yellow   = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            green[i]  = (state == GREEN)  && (cur == CW'(i));
            yellow[i] = (state == YELLOW) && (cur == CW'(i));
        end
        red      = ~(green | yellow);
        ped_walk = (state == WALK);
    end

    // Phase timer: restarts on every state change, saturates instead of wrapping while green rests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  tmr <= '0;
        else if (state_nxt != state) tmr <= '0;
        else if (tmr != tmr_sat)     tmr <= tmr + 1'b1;
    end

    // Served approach; only moves when a new green is granted, so walk leaves the rotation intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           cur <= CUR_RST;
        else if (enter_green) cur <= pick_idx;
    end

    // Demand latches; the grant clear outranks a detector still asserting on that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dem      <= '0;
            ped_pend <= 1'b0;
        end else begin
            dem      <= (dem | (det & ~green)) & ~(enter_green ? (N_WAYS'(1) << pick_idx) : '0);
            ped_pend <= (ped_pend | ped_req) & ~enter_walk;
        end
    end

    // Red-light camera: rising stop edge seen while the approach shows red fires one pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stop_q <= '0;
            cam    <= '0;
        end else begin
            stop_q <= stop;
            cam    <= stop & ~stop_q & red;
        end
    end

endmodule

// File: tb/tb_transito_multi.sv
// Directed bench for transito_multi with hand-derived phase lengths.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: not applicable.
module tb_transito_multi;
    import transito_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] det;
    logic [N-1:0] stop;
    logic         ped_req;
    logic [N-1:0] green;
    logic [N-1:0] yellow;
    logic [N-1:0] red;
    logic         ped_walk;
    logic [N-1:0] cam;
    logic [8:0]   lamps;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt0;
    int cnt3;

    // Lamp word: bit 8 walk, bits 7:4 yellow, bits 3:0 green; all-red is zero.
    localparam logic [8:0] ALLRED_W = 9'h000;
    localparam logic [8:0] WALK_W   = 9'h100;

    transito_multi #(
        .N_WAYS    (4),
        .GREEN_MIN (8),
        .GREEN_MAX (24),
        .YELLOW_T  (3),
        .ALLRED_T  (2),
        .WALK_T    (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .det      (det),
        .stop     (stop),
        .ped_req  (ped_req),
        .green    (green),
        .yellow   (yellow),
        .red      (red),
        .ped_walk (ped_walk),
        .cam      (cam)
    );

    always #5 clk = ~clk;

    assign lamps = {ped_walk, yellow, green};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a lamp pattern; an expired budget shows up as a failed compare.
    task automatic wait_for(input string tag, input logic [8:0] want, input int budget);
        int k;
        k = 0;
        while (lamps !== want && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(lamps), 32'(want));
    endtask

    // Counts cycles the pattern holds, starting with the current sample.
    task automatic measure(input string tag, input logic [8:0] want, input int exp_len);
        int n;
        n = 0;
        while (lamps === want && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp_len);
    endtask

    task automatic do_reset();
        det     = '0;
        stop    = '0;
        ped_req = 1'b0;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b1;
    endtask

    initial begin
        det     = '0;
        stop    = '0;
        ped_req = 1'b0;
        reset   = 1'b0;

        // Reset values, then two all-red cycles into IDLE with nothing requested.
        @(negedge clk);
        chk("rst_red",    32'(red),      32'hF);
        chk("rst_green",  32'(green),    32'h0);
        chk("rst_yellow", 32'(yellow),   32'h0);
        chk("rst_walk",   32'(ped_walk), 32'h0);
        chk("rst_cam",    32'(cam),      32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_red",   32'(red),       32'hF);
        chk("idle_lamps", 32'(lamps),     32'h0);
        chk("idle_state", 32'(dut.state), 32'(IDLE));

        // det[2] held: green rests, timer saturates, then an outside request maxes it out at once.
        do_reset();
        det = 4'b0100;
        wait_for("g2_up", 9'h004, 10);
        repeat (38) @(negedge clk);
        chk("g2_rest", 32'(lamps),   32'h004);
        chk("g2_tmr",  32'(dut.tmr), 32'd23);
        det = 4'b0000;
        repeat (5) @(negedge clk);
        chk("g2_rest_nodet", 32'(lamps), 32'h004);
        det = 4'b0001;
        @(negedge clk);
        det = 4'b0000;
        chk("g2_latch", 32'(lamps), 32'h004);
        @(negedge clk);
        chk("g2_to_y", 32'(lamps), 32'h040);
        measure("y2_len",  9'h040, 3);
        measure("ar2_len", ALLRED_W, 2);
        chk("g0_after_g2", 32'(lamps), 32'h001);

        // det[0] and det[3] pulsed together: minimum green on 0, then 3.
        do_reset();
        det = 4'b1001;
        @(negedge clk);
        det = 4'b0000;
        wait_for("g0_up", 9'h001, 10);
        chk("g0_red", 32'(red), 32'hE);
        measure("g0_min",  9'h001, 8);
        measure("y0_len",  9'h010, 3);
        chk("ar_red", 32'(red), 32'hF);
        measure("ar0_len", ALLRED_W, 2);
        chk("g3_next", 32'(lamps), 32'h008);

        // det[1] held with det[2] waiting: green[1] maxes out at 24, then green[2] gets its minimum.
        do_reset();
        det = 4'b0110;
        @(negedge clk);
        det = 4'b0010;
        wait_for("g1_up", 9'h002, 10);
        measure("g1_max",  9'h002, 24);
        measure("y1_len",  9'h020, 3);
        measure("ar1_len", ALLRED_W, 2);
        chk("g2_next", 32'(lamps), 32'h004);
        measure("g2_min",  9'h004, 8);
        det = 4'b0000;

        // Pedestrian request during green[0] with det[1] pending: walk precedes green[1].
        do_reset();
        det = 4'b0011;
        @(negedge clk);
        det = 4'b0000;
        wait_for("p_g0_up", 9'h001, 10);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        // Two of the eight green cycles are already behind us.
        measure("p_g0_rest", 9'h001, 6);
        measure("p_y0",      9'h010, 3);
        measure("p_ar_a",    ALLRED_W, 2);
        chk("walk_red", 32'(red), 32'hF);
        measure("p_walk",    WALK_W, 6);
        measure("p_ar_b",    ALLRED_W, 2);
        chk("p_g1", 32'(lamps), 32'h002);

        // Camera: held stop on red fires once; stop on green never fires.
        do_reset();
        repeat (4) @(negedge clk);
        stop = 4'b1000;
        cnt3 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) chk("cam3_first", 32'(cam), 32'h8);
            if (cam[3]) cnt3++;
            if (c == 4) stop = 4'b0000;
        end
        chk("cam3_once", cnt3, 1);

        det = 4'b0001;
        @(negedge clk);
        det = 4'b0000;
        wait_for("cam_g0_up", 9'h001, 10);
        stop = 4'b1001;
        cnt0 = 0;
        cnt3 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cam[0]) cnt0++;
            if (cam[3]) cnt3++;
        end
        chk("cam0_green", cnt0, 0);
        chk("cam3_red",   cnt3, 1);

        // Reset asserted mid-yellow while a camera pulse is live: everything drops at once.
        stop = 4'b0000;
        det  = 4'b0010;
        @(negedge clk);
        det  = 4'b0000;
        wait_for("rst_y0_up", 9'h010, 20);
        stop = 4'b0100;
        @(posedge clk);
        #1;
        chk("pre_cam",    32'(cam),    32'h4);
        chk("pre_yellow", 32'(yellow), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_red_async",    32'(red),      32'hF);
        chk("ar_yellow_async", 32'(yellow),   32'h0);
        chk("ar_green_async",  32'(green),    32'h0);
        chk("ar_walk_async",   32'(ped_walk), 32'h0);
        chk("ar_cam_async",    32'(cam),      32'h0);
        @(negedge clk);
        stop  = 4'b0000;
        reset = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
